ttl_7402_quad_nor: RTL and testbench

TTL_7402_QUAD_NOR -- requirements
Module: ttl_7402_quad_nor

---
 rtl/ttl_pkg.sv | 11 +
 rtl/ttl_7402_quad_nor_nor2_cell.sv | 38 +++
 rtl/ttl_7402_quad_nor.sv | 52 +++++
 tb/tb_ttl_7402_quad_nor.sv | 122 ++++++++++++
 4 files changed

// File: rtl/ttl_pkg.sv
// Shared constants for the 7402-style quad two-input NOR block.
package ttl_pkg;

  localparam int   NUM_GATES       = 4;
  localparam logic Y_RESET_DEFAULT = 1'b0;

  function automatic logic nor2(input logic a, input logic b);
    return ~(a | b);
  endfunction

endpackage

// File: rtl/ttl_7402_quad_nor_nor2_cell.sv
// One two-input NOR gate with an optional single output flip-flop.
module nor2_cell
  import ttl_pkg::*;
#(
  parameter int   OUTPUT_REG  = 1,
  parameter logic Y_RESET_VAL = Y_RESET_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic y
);

  logic nor_d;

  assign nor_d = nor2(a, b);

  generate
    if (OUTPUT_REG != 0) begin : g_reg
      logic y_q;

      // Reset wins over the NOR update; no other state exists in the cell.
      always_ff @(posedge clk) begin
        if (reset) y_q <= Y_RESET_VAL;
        else       y_q <= nor_d;
      end

      assign y = y_q;
    end else begin : g_comb
      logic unused_clk_reset;

      assign unused_clk_reset = clk ^ reset;
      assign y                = nor_d;
    end
  endgenerate

endmodule

// File: rtl/ttl_7402_quad_nor.sv
// Quad independent two-input NOR gates; optional registered outputs.
module ttl_7402_quad_nor
  import ttl_pkg::*;
#(
  parameter int   OUTPUT_REG  = 1,
  parameter logic Y_RESET_VAL = Y_RESET_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic A1,
  input  logic B1,
  input  logic A2,
  input  logic B2,
  input  logic A3,
  input  logic B3,
  input  logic A4,
  input  logic B4,
  output logic Y1,
  output logic Y2,
  output logic Y3,
  output logic Y4
);

  logic [NUM_GATES-1:0] a_vec;
  logic [NUM_GATES-1:0] b_vec;
  logic [NUM_GATES-1:0] y_vec;

  assign a_vec = {A4, A3, A2, A1};
  assign b_vec = {B4, B3, B2, B1};

  // Each gate gets its own cell so no operand can reach another output.
  generate
    for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
      nor2_cell #(
        .OUTPUT_REG  (OUTPUT_REG),
        .Y_RESET_VAL (Y_RESET_VAL)
      ) u_cell (
        .clk   (clk),
        .reset (reset),
        .a     (a_vec[g]),
        .b     (b_vec[g]),
        .y     (y_vec[g])
      );
    end
  endgenerate

  assign Y1 = y_vec[0];
  assign Y2 = y_vec[1];
  assign Y3 = y_vec[2];
  assign Y4 = y_vec[3];

endmodule

// File: tb/tb_ttl_7402_quad_nor.sv
// Bench for the quad NOR: registered instance via scoreboard, combinational instance directly.
module tb_ttl_7402_quad_nor;

  // Clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Registered DUT signals
  logic A1 = 1'b1, B1 = 1'b1, A2 = 1'b1, B2 = 1'b1;
  logic A3 = 1'b1, B3 = 1'b1, A4 = 1'b1, B4 = 1'b1;
  logic Y1, Y2, Y3, Y4;
  logic [3:0] y_reg;
  assign y_reg = {Y4, Y3, Y2, Y1};

  // Combinational DUT signals
  logic [3:0] ca = 4'b1111;
  logic [3:0] cb = 4'b1111;
  logic cy1, cy2, cy3, cy4;
  logic [3:0] y_comb;
  assign y_comb = {cy4, cy3, cy2, cy1};

  ttl_7402_quad_nor #(.OUTPUT_REG(1), .Y_RESET_VAL(1'b0)) dut (
    .clk(clk), .reset(reset),
    .A1(A1), .B1(B1), .A2(A2), .B2(B2),
    .A3(A3), .B3(B3), .A4(A4), .B4(B4),
    .Y1(Y1), .Y2(Y2), .Y3(Y3), .Y4(Y4)
  );

  ttl_7402_quad_nor #(.OUTPUT_REG(0), .Y_RESET_VAL(1'b0)) dut_comb (
    .clk(clk), .reset(reset),
    .A1(ca[0]), .B1(cb[0]), .A2(ca[1]), .B2(cb[1]),
    .A3(ca[2]), .B3(cb[2]), .A4(ca[3]), .B4(cb[3]),
    .Y1(cy1), .Y2(cy2), .Y3(cy3), .Y4(cy4)
  );

  // Scoreboard state
  logic [3:0] exp_q[$];
  logic [3:0] prev_exp = 4'b0000;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // Driver: apply one vector just after an edge; the output is due at the next edge.
  // Until then the outputs must still hold the previous vector's result.
  task automatic apply(input string name, input logic r, input logic [3:0] a,
                       input logic [3:0] b, input logic [3:0] exp);
    @(posedge clk);
    #1;
    reset = r;
    {A4, A3, A2, A1} = a;
    {B4, B3, B2, B1} = b;
    exp_q.push_back(exp);
    #3;
    check({name, "_hold"}, y_reg, prev_exp);
    prev_exp = exp;
  endtask

  task automatic apply_comb(input string name, input logic [3:0] a,
                            input logic [3:0] b, input logic [3:0] exp);
    ca = a;
    cb = b;
    #1;
    check(name, y_comb, exp);
  endtask

  // Monitor: an entry pushed before an edge is captured at that edge; compare mid-cycle.
  initial begin
    logic [3:0] e;
    forever begin
      @(posedge clk);
      if (exp_q.size() > 0) begin
        @(negedge clk);
        e = exp_q.pop_front();
        check("sb_y", y_reg, e);
      end
    end
  end

  initial begin
    // Combinational build, before any clock edge and with reset held high.
    apply_comb("comb_g3_00", 4'b1011, 4'b1011, 4'b0100);
    apply_comb("comb_indep", 4'b1010, 4'b1100, 4'b0001);
    apply_comb("comb_all0",  4'b0000, 4'b0000, 4'b1111);

    // Registered build
    apply("rst_ones",   1'b1, 4'b1111, 4'b1111, 4'b0000);
    apply("rst_prio",   1'b1, 4'b0000, 4'b0000, 4'b0000);
    apply("first_edge", 1'b0, 4'b0000, 4'b0000, 4'b1111);
    apply("g1_10",      1'b0, 4'b0001, 4'b0000, 4'b1110);
    apply("g1_01",      1'b0, 4'b0000, 4'b0001, 4'b1110);
    apply("g1_11",      1'b0, 4'b0001, 4'b0001, 4'b1110);
    apply("indep",      1'b0, 4'b1010, 4'b1100, 4'b0001);
    apply("a2_high",    1'b0, 4'b0010, 4'b0000, 4'b1101);
    apply("a2_low",     1'b0, 4'b0000, 4'b0000, 4'b1111);
    apply("rst_mid",    1'b1, 4'b0000, 4'b0000, 4'b0000);
    apply("post_rst",   1'b0, 4'b0000, 4'b0000, 4'b1111);
    apply("all_a",      1'b0, 4'b1111, 4'b0000, 4'b0000);
    apply("alt",        1'b0, 4'b0101, 4'b1010, 4'b0000);
    apply("mixed",      1'b0, 4'b0000, 4'b0110, 4'b1001);

    // Bounded drain of the scoreboard.
    repeat (3) @(posedge clk);
    #6;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain: %0d expected results left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
